// File: rtl/router_pkg.sv
// Shared definitions for the router packet reader.
//   fetch_state_t : fetch FSM states (IDLE, WAIT_HDR, FETCH)
//   rd_entry_t    : one output-buffer entry (byte + header/parity markers)
//   header layout : {len[7:2], addr[1:0]}
package router_pkg;

  localparam int unsigned LEN_W           = 6;
  localparam int unsigned ADDR_W          = 2;
  localparam int unsigned HDR_ADDR_LSB    = 0;
  localparam int unsigned HDR_LEN_LSB     = HDR_ADDR_LSB + ADDR_W;
  localparam int unsigned TIMEOUT_DEFAULT = 30;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_HDR = 2'd1,
    ST_FETCH    = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } rd_entry_t;

  function automatic logic [LEN_W-1:0] hdr_len(input logic [7:0] hdr);
    return hdr[HDR_LEN_LSB +: LEN_W];
  endfunction

  function automatic logic [ADDR_W-1:0] hdr_addr(input logic [7:0] hdr);
    return hdr[HDR_ADDR_LSB +: ADDR_W];
  endfunction

endpackage

// File: rtl/router_pkt_reader_if.sv
// Bus bundle of the router packet reader.
//   FIFO side : fifo_empty, fifo_dout (in), fifo_r_en (out)
//   Stream    : out_ready (in), out_data/out_valid/out_sop/out_eop (out)
//   Status    : pkt_addr, pkt_done, parity_err, soft_rst_out (out)
// master = the reader, slave = FIFO/downstream/environment.
interface router_pkt_reader_if;

  logic                        fifo_empty;
  logic [7:0]                  fifo_dout;
  logic                        fifo_r_en;
  logic                        out_ready;
  logic [7:0]                  out_data;
  logic                        out_valid;
  logic                        out_sop;
  logic                        out_eop;
  logic [router_pkg::ADDR_W-1:0] pkt_addr;
  logic                        pkt_done;
  logic                        parity_err;
  logic                        soft_rst_out;

  modport master (
    input  fifo_empty, fifo_dout, out_ready,
    output fifo_r_en, out_data, out_valid, out_sop, out_eop,
           pkt_addr, pkt_done, parity_err, soft_rst_out
  );

  modport slave (
    output fifo_empty, fifo_dout, out_ready,
    input  fifo_r_en, out_data, out_valid, out_sop, out_eop,
           pkt_addr, pkt_done, parity_err, soft_rst_out
  );

endinterface

// File: rtl/router_rd_skid.sv
// Two-entry in-order output buffer for the packet reader.
//   clk, rst         : clock, synchronous active-high reset
//   flush            : synchronous clear (timeout flush)
//   push, push_entry : write one entry (caller guarantees space)
//   out_ready        : downstream accept
//   out_valid/data/sop/eop : head entry, held stable until accepted
//   count            : number of entries held (0..2)
module router_rd_skid
  import router_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  rd_entry_t  push_entry,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_sop,
  output logic       out_eop,
  output logic [1:0] count
);

  rd_entry_t head_q;
  rd_entry_t tail_q;
  logic      head_vld;
  logic      tail_vld;
  logic      pop;

  always_comb begin
    pop       = head_vld & out_ready;
    out_valid = head_vld;
    out_data  = head_q.data;
    out_sop   = head_q.sop;
    out_eop   = head_q.eop;
    count     = 2'(head_vld) + 2'(tail_vld);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q   <= '0;
      tail_q   <= '0;
      head_vld <= 1'b0;
      tail_vld <= 1'b0;
    end else begin
      unique case ({push, pop})
        2'b11: begin
          if (tail_vld) begin
            head_q <= tail_q;
            tail_q <= push_entry;
          end else begin
            head_q <= push_entry;
          end
        end
        2'b10: begin
          if (!head_vld) begin
            head_q   <= push_entry;
            head_vld <= 1'b1;
          end else begin
            tail_q   <= push_entry;
            tail_vld <= 1'b1;
          end
        end
        2'b01: begin
          head_q   <= tail_q;
          head_vld <= tail_vld;
          tail_vld <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/router_pkt_reader.sv
// Router packet reader: pulls {header, payload, parity} packets out of a
// packet FIFO, streams them downstream through a 2-entry buffer, checks
// parity, and requests a FIFO flush when downstream stalls too long.
//   clk, rst : clock, synchronous active-high reset
//   bus      : router_pkt_reader_if.master (FIFO side, output stream, status)
//   TIMEOUT  : consecutive stalled cycles before a flush request
module router_pkt_reader
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  router_pkt_reader_if.master    bus
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam int unsigned CNT_W = LEN_W + 1;

  fetch_state_t      state;
  logic [CNT_W-1:0]  fetch_cnt;
  logic              rd_inflight;
  logic              inflight_sop;
  logic              inflight_eop;
  logic [7:0]        parity_acc;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [ADDR_W-1:0] pkt_addr_q;
  logic              pkt_done_q;
  logic              parity_err_q;

  logic              out_valid;
  logic [1:0]        buf_count;
  logic              stall;
  logic              pop;
  logic              flush;
  logic [2:0]        occupancy;
  logic              space;
  logic              rd_en;
  logic              push;
  rd_entry_t         arrive_entry;

  always_comb begin
    stall = out_valid & ~bus.out_ready;
    pop   = out_valid & bus.out_ready;
    flush = stall && (tmo_cnt == TMO_W'(TIMEOUT - 1));
    // Occupancy nets out this cycle's pop so a steady stream can issue a
    // read every cycle; without it the buffer would throttle to 1/2 rate.
    occupancy = 3'(buf_count) + 3'(rd_inflight) - 3'(pop);
    space     = occupancy < 3'd2;
    rd_en     = 1'b0;
    if (!rst && !flush && !bus.fifo_empty && space &&
        (state == ST_IDLE || state == ST_FETCH))
      rd_en = 1'b1;
    push         = rd_inflight & ~flush;
    arrive_entry = '{data: bus.fifo_dout, sop: inflight_sop, eop: inflight_eop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      fetch_cnt    <= '0;
      rd_inflight  <= 1'b0;
      inflight_sop <= 1'b0;
      inflight_eop <= 1'b0;
      parity_acc   <= '0;
      tmo_cnt      <= '0;
      pkt_addr_q   <= '0;
      pkt_done_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else if (flush) begin
      // The FIFO is being soft-reset this cycle: drop the packet in progress
      // and any byte already on fifo_dout.
      state        <= ST_IDLE;
      fetch_cnt    <= '0;
      rd_inflight  <= 1'b0;
      inflight_sop <= 1'b0;
      inflight_eop <= 1'b0;
      parity_acc   <= '0;
      tmo_cnt      <= '0;
      pkt_done_q   <= 1'b0;
    end else begin
      tmo_cnt      <= stall ? tmo_cnt + TMO_W'(1) : '0;
      rd_inflight  <= rd_en;
      inflight_sop <= rd_en && (state == ST_IDLE);
      inflight_eop <= rd_en && (state == ST_FETCH) && (fetch_cnt == CNT_W'(1));
      pkt_done_q   <= 1'b0;

      if (rd_inflight) begin
        if (inflight_sop) begin
          parity_acc <= bus.fifo_dout;
          pkt_addr_q <= hdr_addr(bus.fifo_dout);
        end else if (inflight_eop) begin
          pkt_done_q   <= 1'b1;
          parity_err_q <= (parity_acc != bus.fifo_dout);
          parity_acc   <= '0;
        end else begin
          parity_acc <= parity_acc ^ bus.fifo_dout;
        end
      end

      unique case (state)
        ST_IDLE: begin
          if (rd_en) state <= ST_WAIT_HDR;
        end
        ST_WAIT_HDR: begin
          if (rd_inflight) begin
            fetch_cnt <= CNT_W'(hdr_len(bus.fifo_dout)) + CNT_W'(1);
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (rd_en) begin
            fetch_cnt <= fetch_cnt - CNT_W'(1);
            if (fetch_cnt == CNT_W'(1)) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  router_rd_skid u_skid (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .push       (push),
    .push_entry (arrive_entry),
    .out_ready  (bus.out_ready),
    .out_valid  (out_valid),
    .out_data   (bus.out_data),
    .out_sop    (bus.out_sop),
    .out_eop    (bus.out_eop),
    .count      (buf_count)
  );

  assign bus.out_valid    = out_valid;
  assign bus.fifo_r_en    = rd_en;
  assign bus.soft_rst_out = flush;
  assign bus.pkt_addr     = pkt_addr_q;
  assign bus.pkt_done     = pkt_done_q;
  assign bus.parity_err   = parity_err_q;

endmodule

// File: tb/tb_router_pkt_reader.sv
module tb_router_pkt_reader;
  import router_pkg::*;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } beat_t;

  typedef struct {
    logic [1:0] addr;
    logic       perr;
  } done_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        gap = 1'b0;
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned rd_count = 0;
  int unsigned xfer_cnt = 0;
  int unsigned done_cnt = 0;

  logic [7:0] fifo_q[$];
  beat_t      exp_q[$];
  done_t      done_q[$];
  beat_t      mon_e;
  done_t      mon_d;

  router_pkt_reader_if bus ();

  router_pkt_reader #(.TIMEOUT(30)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packet FIFO model: data one cycle after a sampled read; cleared by
  // system reset or by the reader's flush request.
  always @(posedge clk) begin
    if (bus.fifo_r_en) begin
      rd_count++;
      check("rd_while_empty", 32'(bus.fifo_empty), 32'd0);
      if (fifo_q.size() != 0) bus.fifo_dout <= fifo_q.pop_front();
      else bus.fifo_dout <= 8'hEE;
    end
    if (rst || bus.soft_rst_out) fifo_q.delete();
    bus.fifo_empty <= gap || (fifo_q.size() == 0);
  end

  // Output monitor / scoreboard.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      xfer_cnt++;
      if (exp_q.size() == 0) begin
        check("unexpected_byte", 32'({bus.out_data, bus.out_sop, bus.out_eop}), 32'hFFFF);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_beat", 32'({bus.out_data, bus.out_sop, bus.out_eop}), 32'(mon_e));
      end
    end
    if (bus.pkt_done) begin
      done_cnt++;
      if (done_q.size() == 0) begin
        check("unexpected_done", 32'(bus.pkt_done), 32'd0);
      end else begin
        mon_d = done_q.pop_front();
        check("done_addr", 32'(bus.pkt_addr), 32'(mon_d.addr));
        check("done_perr", 32'(bus.parity_err), 32'(mon_d.perr));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pkt(input logic [1:0] addr, input int unsigned len, input logic corrupt);
    logic [7:0] hdr;
    logic [7:0] p;
    logic [7:0] b;
    hdr = {6'(len), addr};
    p   = hdr;
    fifo_q.push_back(hdr);
    exp_q.push_back('{data: hdr, sop: 1'b1, eop: 1'b0});
    for (int unsigned i = 0; i < len; i++) begin
      b = 8'($urandom_range(0, 255));
      p ^= b;
      fifo_q.push_back(b);
      exp_q.push_back('{data: b, sop: 1'b0, eop: 1'b0});
    end
    p = p ^ {7'd0, corrupt};
    fifo_q.push_back(p);
    exp_q.push_back('{data: p, sop: 1'b0, eop: 1'b1});
    done_q.push_back('{addr: addr, perr: corrupt});
  endtask

  task automatic wait_drain(input string tag, input int unsigned budget);
    int unsigned n = 0;
    while (((exp_q.size() != 0) || (done_q.size() != 0)) && (n < budget)) begin
      tick();
      n++;
    end
    check(tag, 32'(exp_q.size() + done_q.size()), 32'd0);
  endtask

  task automatic wait_xfers(input string tag, input int unsigned want);
    int unsigned x0 = xfer_cnt;
    int unsigned n  = 0;
    while ((xfer_cnt - x0 < want) && (n < 200)) begin
      tick();
      n++;
    end
    check(tag, 32'(xfer_cnt - x0 >= want), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_data"},  32'(bus.out_data), 32'd0);
    check({tag, "_sop"},   32'(bus.out_sop), 32'd0);
    check({tag, "_eop"},   32'(bus.out_eop), 32'd0);
    check({tag, "_addr"},  32'(bus.pkt_addr), 32'd0);
    check({tag, "_done"},  32'(bus.pkt_done), 32'd0);
    check({tag, "_perr"},  32'(bus.parity_err), 32'd0);
    check({tag, "_srst"},  32'(bus.soft_rst_out), 32'd0);
    check({tag, "_ren"},   32'(bus.fifo_r_en), 32'd0);
    check({tag, "_state"}, 32'(dut.state), 32'(ST_IDLE));
    check({tag, "_count"}, 32'(dut.buf_count), 32'd0);
  endtask

  initial begin
    int unsigned d0;
    int unsigned r0;
    int unsigned x1;

    bus.out_ready = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    bus.out_ready = 1'b1;

    // Header 8'h39: len 14, addr 01, good parity.
    d0 = done_cnt;
    send_pkt(2'b01, 14, 1'b0);
    wait_drain("pkt39_drain", 200);
    check("pkt39_done_cnt", 32'(done_cnt - d0), 32'd1);
    check("pkt39_addr", 32'(bus.pkt_addr), 32'd1);
    check("pkt39_perr", 32'(bus.parity_err), 32'd0);

    // Corrupted parity, then a good packet clears the flag.
    send_pkt(2'b01, 14, 1'b1);
    wait_drain("badpar_drain", 200);
    check("badpar_perr", 32'(bus.parity_err), 32'd1);
    send_pkt(2'b11, 6, 1'b0);
    wait_drain("goodpar_drain", 200);
    check("goodpar_perr", 32'(bus.parity_err), 32'd0);

    // Zero-length packet: header 8'h02.
    r0 = rd_count;
    send_pkt(2'b10, 0, 1'b0);
    wait_drain("len0_drain", 100);
    check("len0_reads", 32'(rd_count - r0), 32'd2);
    check("len0_addr", 32'(bus.pkt_addr), 32'd2);

    // Downstream stall of 5 cycles mid-payload.
    send_pkt(2'b00, 63, 1'b0);
    wait_xfers("stall_start", 10);
    bus.out_ready = 1'b0;
    repeat (5) tick();
    check("stall_count", 32'(dut.buf_count), 32'd2);
    check("stall_ren", 32'(bus.fifo_r_en), 32'd0);
    check("stall_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b1;
    x1 = xfer_cnt;
    repeat (8) tick();
    check("resume_rate", 32'(xfer_cnt - x1), 32'd8);
    wait_drain("stall_drain", 200);

    // Stall long enough to trigger the flush.
    send_pkt(2'b11, 63, 1'b0);
    wait_xfers("tmo_start", 4);
    check("tmo_valid_before", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b0;
    for (int unsigned s = 1; s <= 30; s++) begin
      check($sformatf("tmo_pulse_%0d", s), 32'(bus.soft_rst_out), 32'(s == 30));
      tick();
    end
    check("tmo_after_valid", 32'(bus.out_valid), 32'd0);
    check("tmo_after_state", 32'(dut.state), 32'(ST_IDLE));
    check("tmo_after_srst", 32'(bus.soft_rst_out), 32'd0);
    check("tmo_after_count", 32'(dut.buf_count), 32'd0);
    exp_q.delete();
    done_q.delete();
    bus.out_ready = 1'b1;
    send_pkt(2'b01, 5, 1'b0);
    wait_drain("tmo_recover_drain", 100);

    // Reset in the middle of a payload.
    send_pkt(2'b10, 40, 1'b0);
    wait_xfers("rst_start", 5);
    rst = 1'b1;
    tick();
    check_all_zero("midrst");
    rst = 1'b0;
    exp_q.delete();
    done_q.delete();
    send_pkt(2'b01, 3, 1'b0);
    wait_drain("rst_recover_drain", 100);

    // FIFO empty gaps during a packet.
    send_pkt(2'b01, 20, 1'b0);
    for (int unsigned i = 0; i < 40; i++) begin
      gap = (i % 3 == 1) || (i % 7 == 3);
      tick();
    end
    gap = 1'b0;
    wait_drain("gap_drain", 200);
    check("gap_addr", 32'(bus.pkt_addr), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
